onehot_seq_dec: RTL
===================

Name: onehot_seq_dec

Overview:
- Parametrised binary-to-one-hot decoder with a registered output and a valid/ready handshake on both sides.
- Two modes:
  - Single: one index in, one one-hot beat out.
  - Sweep: one command in, a burst of consecutive one-hot beats out (walking one), wrapping at OUT_W.
- Generates row/buffer select vectors for the PE array and scratchpad banks, replacing fixed 4-to-16 decode.

Parameters:
IDX_W, 4, width of index and count fields
OUT_W, 16, number of one-hot output lines; legal range 2..2**IDX_W
SWEEP_EN, 1, 1 enables sweep mode; 0 makes in_mode ignored (treated as single)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  command valid
in_ready  output  1  command accepted when in_valid & in_ready
in_mode  input  1  0 = single decode, 1 = sweep
in_idx  input  IDX_W  start index (bit position, 0-based)
in_cnt  input  IDX_W  sweep length minus 1 (beats = in_cnt+1); ignored in single mode
out_valid  output  1  out_onehot valid
out_ready  input  1  downstream accepts beat when out_valid & out_ready
out_onehot  output  OUT_W  one-hot select; bit k set for index k
out_last  output  1  final beat of the current command
out_err  output  1  beat index >= OUT_W; out_onehot is all zeros on such beats
busy  output  1  state != IDLE or out_valid

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high.
  - Reset is sampled every edge.
  - rst=1 forces state IDLE, out_valid=0, out_onehot=0, out_last=0, out_err=0, internal idx/remaining counters=0, busy=0.
  - Mid-burst reset aborts with no further beats.
- Mapping: index k -> out_onehot[k]=1, all other bits 0. Index 0 maps to bit 0, no offset.
- Out-of-range index: index >= OUT_W gives out_onehot=0 and out_err=1 for that beat only. It is still a handshaked beat.
- State machine has two states, IDLE and EMIT. The output register is a 1-entry skid-free stage.
- in_ready = (state==IDLE) & (!out_valid | out_ready). Combinational from state/out_valid/out_ready only, never from in_valid.
- Accept in single mode (or SWEEP_EN=0):
  - Next cycle: out_valid=1, decode of in_idx, out_last=1.
  - State stays IDLE.
  - Latency from accept to out_valid is exactly 1 cycle.
- Accept in sweep mode:
  - Next cycle: first beat at in_idx.
  - remaining = in_cnt.
  - out_last=1 if in_cnt==0, else state goes to EMIT.
- EMIT:
  - On each output handshake, idx <= (idx==OUT_W-1) ? 0 : idx+1, and remaining decrements.
  - The beat with remaining==0 carries out_last=1; its handshake returns the state to IDLE.
  - Wrap-around is at OUT_W, not 2**IDX_W.
  - Out-of-range start indices increment unchanged until they reach 2**IDX_W-1, then wrap to 0 (mod 2**IDX_W). Each such beat flags out_err.
- Backpressure: while out_valid & !out_ready, out_onehot, out_last and out_err hold stable; no index advance.
- Back-to-back throughput: a new command may be accepted in the same cycle the last beat handshakes, giving one beat per cycle with no bubble.
- Sweep length: maximum is 2**IDX_W beats. A sweep longer than OUT_W revisits indices; this is legal and not flagged.
- in_mode, in_idx and in_cnt are sampled only on accept. Changes while in_ready=0 are ignored.

Decomposition:
- Shared package holds:
  - localparam MODE_SINGLE=1'b0, MODE_SWEEP=1'b1.
  - State encoding ST_IDLE / ST_EMIT.
  - A function onehot(idx, OUT_W) returning the decoded vector (zero if out of range).
- One natural sub-module: onehot_dec_comb (pure combinational IDX_W -> OUT_W decode with range flag), instantiated once on the next-index path. It is the direct replacement for the old fixed decoder.

Test Plan:
- Reset then single idx=0, out_ready=1 -> one cycle later out_onehot=16'h0001, out_last=1, out_err=0; idx=15 -> 16'h8000.
- Sweep idx=14 cnt=3, out_ready=1 -> beats 16'h4000, 16'h8000, 16'h0001, 16'h0002 on consecutive cycles; out_last only on the 4th; in_ready low for beats 1-3.
- OUT_W=10, single idx=12 -> out_onehot=0, out_err=1, out_last=1; sweep idx=8 cnt=2 -> 10'h100, 10'h200, 10'h001.
- Sweep idx=0 cnt=4 with out_ready toggled 1,0,0,1,... -> output held stable during stalls; exactly 5 beats 0x1, 0x2, 0x4, 0x8, 0x10, no skip or duplicate.
- Back-to-back: single idx=3 then single idx=5 with in_valid held and out_ready=1 -> out_valid continuous, 0x0008 then 0x0020.
- Assert rst during the 2nd beat of sweep idx=0 cnt=7 -> next cycle out_valid=0, out_onehot=0, busy=0, in_ready=1; no further beats.

Source files
------------

// File: rtl/onehot_seq_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onehot_seq_dec_pkg
// Description : Shared mode/state encodings and the one-hot decode function.
// Revision    : 1.0 - initial release
// ============================================================================
package onehot_seq_dec_pkg;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SWEEP  = 1'b1;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_EMIT = 1'b1;

    // Widest decode supported; callers keep the low OUT_W bits.
    localparam int ONEHOT_MAX_W = 256;

    function automatic logic [ONEHOT_MAX_W-1:0] onehot(
        input int unsigned idx,
        input int unsigned out_w
    );
        logic [ONEHOT_MAX_W-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < ONEHOT_MAX_W; k++) begin
            v[k] = (k < out_w) && (idx == k);
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_dec_comb.sv
`default_nettype none
// ============================================================================
// Module      : onehot_dec_comb
// Description : Combinational IDX_W -> OUT_W one-hot decode with range flag.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec_comb
    import onehot_seq_dec_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int OUT_W = 16
) (
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] dec,
    output logic             err
);

    logic [ONEHOT_MAX_W-1:0] w_full;

    assign w_full = onehot(int'(idx), int'(OUT_W));
    assign dec    = w_full[OUT_W-1:0];
    // Out-of-range indices decode to all zeros, so an empty vector means error.
    assign err    = ~|w_full;

endmodule
`default_nettype wire

// File: rtl/onehot_seq_dec.sv
`default_nettype none
// ============================================================================
// Module      : onehot_seq_dec
// Description : Registered one-hot decoder with single and sweep (walking-one)
//               modes and valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_seq_dec
    import onehot_seq_dec_pkg::*;
#(
    parameter int IDX_W    = 4,
    parameter int OUT_W    = 16,
    parameter int SWEEP_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [IDX_W-1:0] in_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_last,
    output logic             out_err,
    output logic             busy
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(OUT_W - 1);
    localparam logic [IDX_W-1:0] c_one      = IDX_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [IDX_W-1:0]   r_rem;
    logic [IDX_W-1:0]   w_rem_nxt;
    logic               r_out_valid;
    logic               w_out_valid_nxt;
    logic               r_last;
    logic               w_last_nxt;
    logic               w_load;
    logic [OUT_W-1:0]   r_onehot;
    logic               r_err;
    logic [OUT_W-1:0]   w_dec;
    logic               w_dec_err;
    logic [IDX_W-1:0]   w_idx_adv;
    logic               w_accept;
    logic               w_out_hs;
    logic               w_sweep;

    assign in_ready   = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_out_hs   = r_out_valid && out_ready;
    assign w_sweep    = (SWEEP_EN != 0) && (in_mode == MODE_SWEEP);
    // Wrap at OUT_W; out-of-range indices count on and wrap mod 2**IDX_W.
    assign w_idx_adv  = (r_idx == c_last_idx) ? '0 : r_idx + c_one;

    assign out_valid  = r_out_valid;
    assign out_onehot = r_onehot;
    assign out_last   = r_last;
    assign out_err    = r_err;
    assign busy       = (r_state != ST_IDLE) || r_out_valid;

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_rem_nxt       = r_rem;
        w_out_valid_nxt = r_out_valid;
        w_last_nxt      = r_last;
        w_load          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_out_valid_nxt = 1'b1;
                    w_idx_nxt       = in_idx;
                    w_load          = 1'b1;
                    if (w_sweep) begin
                        w_rem_nxt  = in_cnt;
                        w_last_nxt = (in_cnt == '0);
                        if (in_cnt != '0) begin
                            w_state_nxt = ST_EMIT;
                        end
                    end else begin
                        w_rem_nxt  = '0;
                        w_last_nxt = 1'b1;
                    end
                end else if (w_out_hs) begin
                    w_out_valid_nxt = 1'b0;
                end
            end
            ST_EMIT: begin
                // Returning to IDLE as the final beat loads lets the next
                // command be accepted on that beat's handshake.
                if (w_out_hs) begin
                    w_idx_nxt  = w_idx_adv;
                    w_rem_nxt  = r_rem - c_one;
                    w_last_nxt = (r_rem == c_one);
                    w_load     = 1'b1;
                    if (r_rem == c_one) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    onehot_dec_comb #(
        .IDX_W (IDX_W),
        .OUT_W (OUT_W)
    ) u_dec (
        .idx (w_idx_nxt),
        .dec (w_dec),
        .err (w_dec_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_last      <= 1'b0;
            r_onehot    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_rem       <= w_rem_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_last      <= w_last_nxt;
            if (w_load) begin
                r_onehot <= w_dec;
                r_err    <= w_dec_err;
            end
        end
    end

endmodule
`default_nettype wire
